// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: owns the fetch PC, reads the combinational instruction memory and
// buffers {pc, instr} pairs in a small prefetch FIFO that feeds decode over valid/ready.
`timescale 1ns/1ps

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [31:0]                     imem_addr,
    input  logic [31:0]                     imem_rdata,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_instr,
    output logic [31:0]                     out_pc,
    output logic [31:0]                     out_pc_plus4,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [31:0]                     fetch_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     fetch_count_q;
    entry_t          held_q;
    logic [31:0]     held_plus4_q;

    logic            pop;
    logic            push;
    logic            full;
    entry_t          head;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = out_valid & out_ready;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept a push.
    assign push = !redirect_valid & (!full | pop);
    assign head = fifo_q[head_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
            held_q        <= '0;
            held_plus4_q  <= '0;
        end else begin
            if (pop) begin
                fetch_count_q <= fetch_count_q + 32'd1;
                held_q        <= head;
                held_plus4_q  <= head.pc + 32'd4;
            end
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                    tail_q     <= tail_q + PW'(1);
                end
                if (pop) begin
                    head_q <= head_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: the entry storage has no reset; an entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= '{pc: fetch_pc_q, instr: imem_rdata};
        end
    end

    assign imem_addr    = fetch_pc_q;
    assign out_valid    = (count_q != '0);
    assign out_pc       = out_valid ? head.pc         : held_q.pc;
    assign out_instr    = out_valid ? head.instr      : held_q.instr;
    assign out_pc_plus4 = out_valid ? head.pc + 32'd4 : held_plus4_q;
    assign fifo_count   = count_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized redirect/ready traffic, compared
// every cycle against a queue-based model of the prefetch buffer.
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid = 1'b0;
    logic [31:0]     redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [31:0]     out_pc;
    logic [31:0]     out_pc_plus4;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     fetch_count;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fifo_count     (fifo_count),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: program at 0x00-0x4C, zero elsewhere.
    logic [31:0] prog [20] = '{
        32'h00000113, 32'h00500193, 32'h00000217, 32'h00a00293, 32'h00128293,
        32'h00520233, 32'hfff18193, 32'hfe019ae3, 32'h00402023, 32'h00002383,
        32'h03404283, 32'h0002a313, 32'h00130313, 32'h00628463, 32'h00000013,
        32'h00100073, 32'h00000393, 32'h00535463, 32'h0000006f, 32'h00008067
    };

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a < 32'h50) return prog[a[6:2]];
        return 32'h0;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    // Reference model: prefetched words in order, plus the next address to fetch.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;
    logic [31:0] m_last_p4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc         = RESET_PC;
        m_fc         = 0;
        m_last_pc    = 0;
        m_last_instr = 0;
        m_last_p4    = 0;
    endtask

    // Advance the model across one clock edge with the inputs currently driven.
    task automatic model_edge();
        ent_t e;
        if (q.size() != 0 && out_ready) begin
            m_fc         = m_fc + 1;
            m_last_pc    = q[0].pc;
            m_last_instr = q[0].instr;
            m_last_p4    = q[0].pc + 32'd4;
            q.pop_front();
        end
        if (redirect_valid) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (q.size() < DEPTH) begin
            e.pc    = m_pc;
            e.instr = imem_word(m_pc);
            q.push_back(e);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("imem_addr", imem_addr, m_pc);
        check("fetch_count", fetch_count, m_fc);
        if (q.size() != 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", out_instr, q[0].instr);
            check("out_pc_plus4", out_pc_plus4, q[0].pc + 32'd4);
        end else begin
            check("held_pc", out_pc, m_last_pc);
            check("held_instr", out_instr, m_last_instr);
            check("held_pc_plus4", out_pc_plus4, m_last_p4);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        compare_all();
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks that it takes effect without a clock.
    task automatic apply_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc_plus4", out_pc_plus4, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] fc_before;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Streaming from reset with decode always ready.
        cycle(1'b0, 32'h0, 1'b1);
        check("t1_pc0", out_pc, 32'h00);
        check("t1_instr0", out_instr, 32'h00000113);
        cycle(1'b0, 32'h0, 1'b1);
        check("t1_pc1", out_pc, 32'h04);
        check("t1_instr1", out_instr, 32'h00500193);
        cycle(1'b0, 32'h0, 1'b1);
        check("t1_pc2", out_pc, 32'h08);
        check("t1_instr2", out_instr, 32'h00000217);
        cycle(1'b0, 32'h0, 1'b1);
        check("t1_fetch_count", fetch_count, 32'd3);

        // Decode stalled: FIFO fills and fetch stops.
        apply_reset();
        cycle(1'b0, 32'h0, 1'b0);
        check("t2_count1", 32'(fifo_count), 32'd1);
        cycle(1'b0, 32'h0, 1'b0);
        check("t2_count2", 32'(fifo_count), 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        check("t2_count_hold", 32'(fifo_count), 32'd2);
        check("t2_imem_addr", imem_addr, 32'h08);
        check("t2_pc_stable", out_pc, 32'h00);
        cycle(1'b0, 32'h0, 1'b1);
        check("t2_pc_a", out_pc, 32'h04);
        cycle(1'b0, 32'h0, 1'b1);
        check("t2_pc_b", out_pc, 32'h08);
        cycle(1'b0, 32'h0, 1'b1);
        check("t2_pc_c", out_pc, 32'h0C);
        check("t2_full", 32'(fifo_count), 32'd2);

        // Redirect flushes the prefetched 0x0C/0x10.
        cycle(1'b1, 32'h28, 1'b0);
        check("t3_flushed", 32'(out_valid), 32'd0);
        check("t3_imem_addr", imem_addr, 32'h28);
        cycle(1'b0, 32'h0, 1'b0);
        check("t3_pc", out_pc, 32'h28);
        check("t3_instr", out_instr, 32'h03404283);
        cycle(1'b0, 32'h0, 1'b1);
        check("t3_pc_next", out_pc, 32'h2C);
        check("t3_instr_next", out_instr, 32'h0002A313);

        // Misaligned target and address wrap.
        cycle(1'b1, 32'h2A, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("t4_align_pc", out_pc, 32'h28);
        check("t4_align_instr", out_instr, 32'h03404283);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("t4_top_pc", out_pc, 32'hFFFF_FFFC);
        check("t4_top_plus4", out_pc_plus4, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("t4_wrap_pc", out_pc, 32'h0);

        // Pop in a redirect cycle counts; back-to-back redirects, last wins.
        fc_before = m_fc;
        check("t5_valid_before", 32'(out_valid), 32'd1);
        cycle(1'b1, 32'h18, 1'b1);
        check("t5_fc_inc", fetch_count, fc_before + 32'd1);
        cycle(1'b1, 32'h44, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("t5_pc", out_pc, 32'h44);
        check("t5_instr", out_instr, 32'h00535463);

        // Randomized traffic with a mid-stream reset in the middle.
        for (int i = 0; i < 800; i++) begin
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            rv  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(0, 32'h60));
            rdy = ($urandom_range(0, 9) < 7);
            cycle(rv, rpc, rdy);
            if (i == 400) begin
                apply_reset();
                cycle(1'b0, 32'h0, 1'b1);
                check("t6_restart_pc", out_pc, 32'h00);
            end
        end
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
